// File: rtl/pcileech_tlp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcileech_tlp_pkg: sideband bit positions and helpers for the RX dword packer
// Revision: 1.0
// ---------------------------------------------------------------------------
package pcileech_tlp_pkg;

    localparam int TUSER_FIRST   = 0;
    localparam int TUSER_LAST    = 1;
    localparam int TUSER_BAR_LSB = 2;

    // Counts contiguous set bits from bit 0, looking at the low 'width' bits only.
    function automatic int unsigned lead_ones(input logic [31:0] keep, input int unsigned width);
        int unsigned cnt;
        logic        run;
        cnt = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((unsigned'(i) < width) && run && keep[i]) begin
                cnt = cnt + 1;
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

    function automatic bit dw_ratio_ok(input int in_dw, input int out_dw);
        return (in_dw > 0) && (out_dw >= in_dw) && ((out_dw % in_dw) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcileech_tlp_dw_packer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcileech_tlp_dw_packer_if: narrow RX beat input plus packed output stream
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pcileech_tlp_dw_packer_if #(
    parameter int IN_DW  = 2,
    parameter int OUT_DW = 4,
    parameter int BAR_W  = 7
);
    logic [32*IN_DW-1:0]  in_data;
    logic [4*IN_DW-1:0]   in_keep;
    logic                 in_last;
    logic [BAR_W-1:0]     in_bar;
    logic                 in_valid;
    logic                 in_ready;

    logic [32*OUT_DW-1:0] out_tdata;
    logic [OUT_DW-1:0]    out_tkeepdw;
    logic [BAR_W+1:0]     out_tuser;
    logic                 out_tlast;
    logic                 out_tvalid;
    logic                 out_tready;

    modport master (
        output in_data, in_keep, in_last, in_bar, in_valid, out_tready,
        input  in_ready, out_tdata, out_tkeepdw, out_tuser, out_tlast, out_tvalid
    );

    modport slave (
        input  in_data, in_keep, in_last, in_bar, in_valid, out_tready,
        output in_ready, out_tdata, out_tkeepdw, out_tuser, out_tlast, out_tvalid
    );
endinterface
`default_nettype wire

// File: rtl/pcileech_tlp_dw_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcileech_tlp_dw_packer: packs IN_DW-dword RX beats into OUT_DW-dword beats
// Revision: 1.0
// ---------------------------------------------------------------------------
module pcileech_tlp_dw_packer
    import pcileech_tlp_pkg::*;
#(
    parameter int IN_DW  = 2,
    parameter int OUT_DW = 4,
    parameter int BAR_W  = 7
) (
    input  wire logic              clk,
    input  wire logic              rst,
    pcileech_tlp_dw_packer_if.slave bus,
    output logic                   has_data,
    output logic                   err_keep,
    output logic [15:0]            tlp_count
);

    localparam int CNT_W = $clog2(OUT_DW + 1);

    if (!dw_ratio_ok(IN_DW, OUT_DW)) begin : g_bad_ratio
        $error("OUT_DW must be an integer multiple of IN_DW");
    end

    logic [CNT_W-1:0]       acc_cnt_q;
    logic [OUT_DW-1:0][31:0] acc_q;
    logic                   first_pending_q;
    logic [BAR_W-1:0]       bar_q;
    logic                   out_valid_q;
    logic [OUT_DW-1:0][31:0] out_data_q;
    logic [OUT_DW-1:0]      out_keep_q;
    logic [BAR_W+1:0]       out_user_q;
    logic                   err_keep_q;
    logic [15:0]            tlp_count_q;

    logic [IN_DW-1:0]       w_kdw;
    logic                   w_accept;
    logic                   w_start;
    logic                   w_complete;
    logic                   w_bad_keep;
    int unsigned            w_lead;
    int unsigned            w_n;
    int unsigned            w_acc;
    int unsigned            w_total;
    logic [BAR_W-1:0]       w_bar;
    logic [BAR_W+1:0]       w_user;
    logic [OUT_DW-1:0][31:0] acc_d;
    logic [OUT_DW-1:0]      w_keep;
    logic                   w_unused_keep;

    assign w_unused_keep = ^bus.in_keep;

    always_comb begin
        w_kdw = '0;
        for (int k = 0; k < IN_DW; k++) begin
            w_kdw[k] = bus.in_keep[4*k];
        end
    end

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_lead     = lead_ones(32'(w_kdw), unsigned'(IN_DW));
    assign w_acc      = 32'(acc_cnt_q);
    assign w_bad_keep = !bus.in_last && !(&w_kdw);
    // A ragged non-last beat is still taken as full so later lanes stay aligned.
    assign w_n        = bus.in_last ? ((w_lead == 0) ? 1 : w_lead) : unsigned'(IN_DW);
    assign w_total    = w_acc + w_n;
    assign w_complete = bus.in_last || (w_total == unsigned'(OUT_DW));
    assign w_start    = first_pending_q && (acc_cnt_q == '0);
    assign w_bar      = w_start ? bus.in_bar : bar_q;

    always_comb begin
        w_user                          = '0;
        w_user[TUSER_FIRST]             = first_pending_q;
        w_user[TUSER_LAST]              = bus.in_last;
        w_user[TUSER_BAR_LSB +: BAR_W]  = w_bar;
    end

    for (genvar j = 0; j < OUT_DW; j++) begin : g_lane
        localparam int unsigned LANE = j;
        logic [31:0] w_lane;
        logic        w_lane_keep;

        always_comb begin
            w_lane = (LANE < w_acc) ? acc_q[j] : 32'd0;
            for (int k = 0; k < IN_DW; k++) begin
                if ((unsigned'(k) < w_n) && (LANE == w_acc + unsigned'(k))) begin
                    w_lane = bus.in_data[32*k +: 32];
                end
            end
            w_lane_keep = (LANE < w_total);
        end

        assign acc_d[j]  = w_lane;
        assign w_keep[j] = w_lane_keep;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q       <= '0;
            acc_q           <= '0;
            first_pending_q <= 1'b1;
            bar_q           <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_keep_q      <= '0;
            out_user_q      <= '0;
            err_keep_q      <= 1'b0;
            tlp_count_q     <= '0;
        end else begin
            if (bus.out_tready) begin
                out_valid_q <= 1'b0;
            end
            if (w_accept) begin
                if (w_bad_keep) begin
                    err_keep_q <= 1'b1;
                end
                if (w_start) begin
                    bar_q <= bus.in_bar;
                end
                if (w_complete) begin
                    acc_cnt_q       <= '0;
                    acc_q           <= '0;
                    out_valid_q     <= 1'b1;
                    out_data_q      <= acc_d;
                    out_keep_q      <= w_keep;
                    out_user_q      <= w_user;
                    first_pending_q <= bus.in_last;
                end else begin
                    acc_cnt_q <= CNT_W'(w_total);
                    acc_q     <= acc_d;
                end
            end
            if (out_valid_q && bus.out_tready && out_user_q[TUSER_LAST]) begin
                tlp_count_q <= tlp_count_q + 16'd1;
            end
        end
    end

    assign bus.in_ready    = !out_valid_q || bus.out_tready;
    assign bus.out_tvalid  = out_valid_q;
    assign bus.out_tdata   = out_data_q;
    assign bus.out_tkeepdw = out_keep_q;
    assign bus.out_tuser   = out_user_q;
    assign bus.out_tlast   = out_user_q[TUSER_LAST];
    assign has_data        = out_valid_q || (acc_cnt_q != '0);
    assign err_keep        = err_keep_q;
    assign tlp_count       = tlp_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pcileech_tlp_dw_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pcileech_tlp_dw_packer: scoreboard bench for the RX dword packer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pcileech_tlp_dw_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        has_data, err_keep;
    logic [15:0] tlp_count;
    logic        has_data8, err_keep8;
    logic [15:0] tlp_count8;

    pcileech_tlp_dw_packer_if #(.IN_DW(2), .OUT_DW(4), .BAR_W(7)) bus ();
    pcileech_tlp_dw_packer_if #(.IN_DW(2), .OUT_DW(8), .BAR_W(7)) bus8 ();

    pcileech_tlp_dw_packer #(.IN_DW(2), .OUT_DW(4), .BAR_W(7)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .has_data(has_data), .err_keep(err_keep), .tlp_count(tlp_count)
    );

    pcileech_tlp_dw_packer #(.IN_DW(2), .OUT_DW(8), .BAR_W(7)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8),
        .has_data(has_data8), .err_keep(err_keep8), .tlp_count(tlp_count8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   keep;
        logic [8:0]   user;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors    = 0;
    int          miscompares = 0;
    logic [15:0] exp_tlps   = 16'd0;
    logic        exp_err    = 1'b0;
    bit          bp_rand    = 1'b0;
    bit          bp_val     = 1'b1;
    int          gap_max    = 0;
    bit          mon_en     = 1'b0;
    bit          prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic [13:0]  prev_side;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic void summarize();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endfunction

    // Sink backpressure changes just after the clock edge so it is stable at negedge.
    initial begin
        bus.out_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_tready = bp_rand ? ($urandom_range(0, 3) != 0) : bp_val;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && mon_en) begin
                if (prev_stall) begin
                    chk("stall_data", bus.out_tdata, prev_data);
                    chk("stall_side", {bus.out_tvalid, bus.out_tkeepdw, bus.out_tuser},
                        {1'b1, prev_side[12:0]});
                end
                chk("in_ready_rule", 128'(bus.in_ready), 128'(!bus.out_tvalid || bus.out_tready));
                if (bus.out_tvalid && bus.out_tready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got data 0x%0h, expected no output beat", bus.out_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_tdata, e.data);
                        chk("out_side", {bus.out_tkeepdw, bus.out_tuser, bus.out_tlast},
                            {e.keep, e.user, e.user[1]});
                        chk("tlp_count", 128'(tlp_count), 128'(exp_tlps));
                        if (e.user[1]) exp_tlps = exp_tlps + 16'd1;
                    end
                end
                prev_stall = bus.out_tvalid && !bus.out_tready;
                prev_data  = bus.out_tdata;
                prev_side  = {1'b1, bus.out_tkeepdw, bus.out_tuser};
            end
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [6:0] br);
        int wd;
        bus.in_data  = d;
        bus.in_keep  = k;
        bus.in_last  = l;
        bus.in_bar   = br;
        bus.in_valid = 1'b1;
        wd = 0;
        while (!bus.in_ready) begin
            @(negedge clk);
            wd++;
            if (wd > 2000) begin
                vectors++;
                miscompares++;
                $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", wd);
                summarize();
                $finish;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        bus.in_keep  = 8'($urandom);
        bus.in_last  = 1'($urandom);
        bus.in_bar   = 7'($urandom);
    endtask

    // Reference: flatten kept dwords of the TLP, then cut into OUT_DW-wide beats.
    task automatic send_tlp(input int nbeats, input logic [1:0] last_kdw, input logic [6:0] bar, input int bad_beat);
        logic [31:0] dws[$];
        logic [63:0] bd[$];
        logic [7:0]  bk[$];
        logic [63:0] d;
        logic [1:0]  kdw;
        logic [7:0]  kb;
        exp_t        e;
        int          len;
        for (int b = 0; b < nbeats; b++) begin
            d   = {$urandom, $urandom};
            kdw = (b == nbeats - 1) ? last_kdw : ((b == bad_beat) ? 2'b01 : 2'b11);
            kb  = {3'($urandom), kdw[1], 3'($urandom), kdw[0]};
            bd.push_back(d);
            bk.push_back(kb);
            if (b != nbeats - 1) begin
                dws.push_back(d[31:0]);
                dws.push_back(d[63:32]);
                if (b == bad_beat) exp_err = 1'b1;
            end else begin
                dws.push_back(d[31:0]);
                if (kdw == 2'b11) dws.push_back(d[63:32]);
            end
        end
        for (int s = 0; s < dws.size(); s += 4) begin
            len    = (dws.size() - s < 4) ? dws.size() - s : 4;
            e.data = '0;
            for (int i = 0; i < len; i++) e.data[32*i +: 32] = dws[s+i];
            e.keep = 4'((1 << len) - 1);
            e.user = {bar, (s + 4 >= dws.size()) ? 1'b1 : 1'b0, (s == 0) ? 1'b1 : 1'b0};
            exp_q.push_back(e);
        end
        for (int b = 0; b < nbeats; b++) begin
            drive_beat(bd[b], bk[b], (b == nbeats - 1), (b == 0) ? bar : 7'($urandom));
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int wd;
        wd = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            wd++;
            if (wd > 2000) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
                summarize();
                $finish;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [255:0] d8;
        logic [63:0]  r;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_keep   = '0;
        bus.in_last   = 1'b0;
        bus.in_bar    = '0;
        bus8.in_valid = 1'b0;
        bus8.in_data  = '0;
        bus8.in_keep  = '0;
        bus8.in_last  = 1'b0;
        bus8.in_bar   = '0;
        bus8.out_tready = 1'b1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tdata", bus.out_tdata, 128'd0);
        chk("rst_side", {bus.out_tvalid, bus.out_tkeepdw, bus.out_tuser, bus.out_tlast,
                         bus.in_ready, has_data, err_keep, tlp_count},
            {1'b0, 4'h0, 9'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Two-beat output TLP, then a 3-dword TLP with a zero top lane.
        send_tlp(4, 2'b11, 7'h01, -1);
        wait_drain();
        chk("tlp_count_t1", 128'(tlp_count), 128'd1);
        send_tlp(2, 2'b01, 7'h04, -1);
        wait_drain();

        // Back-to-back single-dword TLPs at full rate.
        for (int i = 0; i < 8; i++) begin
            chk("b2b_in_ready", 128'(bus.in_ready), 128'd1);
            send_tlp(1, 2'b01, 7'(1 << (i % 7)), -1);
        end
        wait_drain();

        // Output stalled with a full beat held.
        bp_val = 1'b0;
        repeat (2) @(negedge clk);
        send_tlp(1, 2'b11, 7'h08, -1);
        fork
            send_tlp(3, 2'b10, 7'h10, -1);
            begin
                repeat (5) begin
                    chk("stall_in_ready", 128'(bus.in_ready), 128'd0);
                    @(negedge clk);
                end
                bp_val = 1'b1;
            end
        join
        wait_drain();

        // Ragged non-last beat, then randomized traffic with backpressure.
        chk("err_keep_clear", 128'(err_keep), 128'(exp_err));
        bp_rand = 1'b1;
        gap_max = 2;
        send_tlp(3, 2'b11, 7'h20, 1);
        wait_drain();
        chk("err_keep_set", 128'(err_keep), 128'(exp_err));
        for (int i = 0; i < 40; i++) begin
            int nb;
            nb = $urandom_range(1, 6);
            send_tlp(nb, 2'($urandom), 7'(1 << $urandom_range(0, 6)),
                     (nb > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 2)) : -1);
        end
        wait_drain();
        chk("err_keep_sticky", 128'(err_keep), 128'(exp_err));
        chk("tlp_count_total", 128'(tlp_count), 128'(exp_tlps));

        // Asynchronous reset with a partially filled accumulator.
        bp_rand = 1'b0;
        bp_val  = 1'b1;
        gap_max = 0;
        repeat (2) @(negedge clk);
        drive_beat({$urandom, $urandom}, 8'hFF, 1'b0, 7'h02);
        chk("mid_has_data", 128'(has_data), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        mon_en = 1'b0;
        chk("mid_rst_tdata", bus.out_tdata, 128'd0);
        chk("mid_rst_side", {bus.out_tvalid, bus.out_tkeepdw, bus.out_tuser, bus.out_tlast,
                             bus.in_ready, has_data, err_keep, tlp_count},
            {1'b0, 4'h0, 9'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        exp_q.delete();
        exp_tlps   = 16'd0;
        exp_err    = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        send_tlp(2, 2'b11, 7'h40, -1);
        wait_drain();
        chk("post_rst_count", 128'(tlp_count), 128'(exp_tlps));

        // 8-dword output: one 8-dword TLP fills exactly one beat.
        d8 = '0;
        for (int b = 0; b < 4; b++) begin
            r = {$urandom, $urandom};
            d8[64*b +: 64] = r;
            bus8.in_data  = r;
            bus8.in_keep  = 8'hFF;
            bus8.in_last  = (b == 3);
            bus8.in_bar   = (b == 0) ? 7'h01 : 7'($urandom);
            bus8.in_valid = 1'b1;
            @(negedge clk);
        end
        bus8.in_valid = 1'b0;
        chk("w8_data_lo", bus8.out_tdata[127:0], d8[127:0]);
        chk("w8_data_hi", bus8.out_tdata[255:128], d8[255:128]);
        chk("w8_side", {bus8.out_tvalid, bus8.out_tkeepdw, bus8.out_tuser, bus8.out_tlast},
            {1'b1, 8'hFF, 7'h01, 1'b1, 1'b1, 1'b1});
        @(negedge clk);
        chk("w8_count", 128'(tlp_count8), 128'd1);

        summarize();
        $finish;
    end

endmodule
`default_nettype wire
